// File: rtl/rv32_branch_predictor_if.sv
// rv32_branch_predictor_if: fetch-side lookup, prediction and execute-side update signals.
interface rv32_branch_predictor_if;
  logic        lookup_valid;
  logic [31:0] lookup_pc;
  logic        flush;
  logic        pred_valid;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  modport master (
    output lookup_valid, lookup_pc, flush, upd_valid, upd_pc, upd_taken, upd_target,
    input  pred_valid, pred_taken, pred_target
  );
  modport slave (
    input  lookup_valid, lookup_pc, flush, upd_valid, upd_pc, upd_taken, upd_target,
    output pred_valid, pred_taken, pred_target
  );
endinterface

// File: rtl/rv32_branch_predictor.sv
// rv32_branch_predictor: direct-mapped predictor with tag, target and 2-bit counter per entry.
module rv32_branch_predictor #(
  parameter  int ENTRIES = 64,
  localparam int IDX_W = $clog2(ENTRIES),
  localparam int TAG_W = 30 - IDX_W
) (
  input logic clk,
  input logic resetn,
  rv32_branch_predictor_if.slave bus
);
  logic [ENTRIES-1:0] vld;
  logic [1:0]         cnt     [ENTRIES];
  logic [TAG_W-1:0]   tag_mem [ENTRIES];
  logic [31:0]        tgt_mem [ENTRIES];
  logic [IDX_W-1:0]   l_idx, u_idx;
  logic               l_take, u_hit;
  always_comb begin
    l_idx  = bus.lookup_pc[IDX_W+1:2];
    u_idx  = bus.upd_pc[IDX_W+1:2];
    l_take = vld[l_idx] && tag_mem[l_idx] == bus.lookup_pc[31:IDX_W+2] && cnt[l_idx][1];
    u_hit  = vld[u_idx] && tag_mem[u_idx] == bus.upd_pc[31:IDX_W+2];
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      vld <= '0;
      for (int i = 0; i < ENTRIES; i++) cnt[i] <= 2'b01;
    end else if (bus.upd_valid) begin
      if (u_hit)
        cnt[u_idx] <= bus.upd_taken ? (cnt[u_idx] == 2'b11 ? 2'b11 : cnt[u_idx] + 2'b01)
                                    : (cnt[u_idx] == 2'b00 ? 2'b00 : cnt[u_idx] - 2'b01);
      else if (bus.upd_taken) begin
        vld[u_idx] <= 1'b1;
        cnt[u_idx] <= 2'b10;
      end
    end
  end
  // Tag and target are only meaningful behind a valid bit, so they need no reset.
  always_ff @(posedge clk) begin
    if (bus.upd_valid && bus.upd_taken) begin
      tag_mem[u_idx] <= bus.upd_pc[31:IDX_W+2];
      tgt_mem[u_idx] <= bus.upd_target;
    end
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      bus.pred_valid  <= 1'b0;
      bus.pred_taken  <= 1'b0;
      bus.pred_target <= '0;
    end else begin
      bus.pred_valid <= bus.lookup_valid & ~bus.flush;
      if (bus.lookup_valid) begin
        bus.pred_taken  <= l_take;
        bus.pred_target <= l_take ? tgt_mem[l_idx] : bus.lookup_pc + 32'd4;
      end
    end
  end
endmodule

// File: tb/tb_rv32_branch_predictor.sv
// tb_rv32_branch_predictor: directed plus random lookups/updates against a queue-based scoreboard.
module tb_rv32_branch_predictor;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  int vectors = 0;
  int miscompares = 0;
  int edges = 0;
  rv32_branch_predictor_if bus ();
  rv32_branch_predictor #(.ENTRIES(64)) dut (.clk(clk), .resetn(resetn), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) edges++;
  typedef struct {int cyc; logic taken; logic [31:0] tgt;} exp_t;
  exp_t q[$];
  exp_t e_mon;
  bit          m_vld [64];
  logic [23:0] m_tag [64];
  logic [31:0] m_tgt [64];
  int          m_cnt [64];
  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at edge %0d: got 0x%08h expected 0x%08h", name, edges, act, exp);
    end
  endfunction
  always @(negedge clk) begin
    if (bus.pred_valid) begin
      if (q.size() == 0) chk("spurious_pred_valid", 32'd1, 32'd0);
      else begin
        e_mon = q.pop_front();
        chk("pred_cycle", edges, e_mon.cyc);
        chk("pred_taken", {31'd0, bus.pred_taken}, {31'd0, e_mon.taken});
        chk("pred_target", bus.pred_target, e_mon.tgt);
      end
    end else if (q.size() != 0 && q[0].cyc <= edges) begin
      e_mon = q.pop_front();
      chk("missing_pred_valid", 32'd0, 32'd1);
    end
  end
  task automatic step(input logic lv, input logic [31:0] lpc, input logic fl, input logic uv,
                      input logic [31:0] upc, input logic ut, input logic [31:0] utg, input logic rn);
    int li, ui;
    bit hit, tk;
    bus.lookup_valid = lv; bus.lookup_pc = lpc; bus.flush = fl;
    bus.upd_valid = uv; bus.upd_pc = upc; bus.upd_taken = ut; bus.upd_target = utg;
    resetn = rn;
    li = int'(lpc[7:2]);
    ui = int'(upc[7:2]);
    tk = m_vld[li] && m_tag[li] == lpc[31:8] && m_cnt[li] >= 2;
    if (rn && lv && !fl) q.push_back('{edges + 1, tk, tk ? m_tgt[li] : lpc + 32'd4});
    if (!rn) begin
      for (int i = 0; i < 64; i++) begin m_vld[i] = 0; m_cnt[i] = 1; end
    end else if (uv) begin
      hit = m_vld[ui] && m_tag[ui] == upc[31:8];
      if (hit && ut) begin m_cnt[ui] = m_cnt[ui] < 3 ? m_cnt[ui] + 1 : 3; m_tgt[ui] = utg; end
      else if (hit) m_cnt[ui] = m_cnt[ui] > 0 ? m_cnt[ui] - 1 : 0;
      else if (ut) begin m_vld[ui] = 1; m_tag[ui] = upc[31:8]; m_tgt[ui] = utg; m_cnt[ui] = 2; end
    end
    @(posedge clk);
    #1;
  endtask
  task automatic look(input logic [31:0] pc);
    step(1, pc, 0, 0, 0, 0, 0, 1);
  endtask
  task automatic upd(input logic [31:0] pc, input logic t, input logic [31:0] tg);
    step(0, 0, 0, 1, pc, t, tg, 1);
  endtask
  logic [31:0] pool [6] = '{32'h100, 32'h200, 32'h104, 32'hFFFF_FFFC, 32'h1100, 32'h300};
  function automatic logic [31:0] rpc();
    return $urandom_range(0, 3) == 0 ? ($urandom() & 32'hFFFF_FFFC) : pool[$urandom_range(0, 5)];
  endfunction
  initial begin
    for (int i = 0; i < 64; i++) begin m_vld[i] = 0; m_cnt[i] = 1; end
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("reset_pred_valid", {31'd0, bus.pred_valid}, 32'd0);
    chk("reset_pred_taken", {31'd0, bus.pred_taken}, 32'd0);
    chk("reset_pred_target", bus.pred_target, 32'd0);
    @(posedge clk); #1;
    look(32'h100);
    upd(32'h100, 1, 32'h80); look(32'h100);
    upd(32'h100, 0, 0); upd(32'h100, 0, 0); look(32'h100);
    upd(32'h100, 1, 32'h80); look(32'h100);
    repeat (3) upd(32'h100, 1, 32'h80);
    look(32'h100);
    upd(32'h100, 0, 0); look(32'h100);
    look(32'h200);
    upd(32'h200, 1, 32'h40); look(32'h200); look(32'h100);
    step(1, 32'h100, 0, 1, 32'h100, 1, 32'h80, 1);
    look(32'h100);
    look(32'hFFFF_FFFC);
    step(1, 32'h100, 1, 0, 0, 0, 0, 1);
    look(32'h100);
    step(1, 32'h100, 0, 1, 32'h100, 1, 32'h80, 0);
    look(32'h100);
    for (int n = 0; n < 3000; n++)
      step($urandom_range(0, 3) != 0, rpc(), $urandom_range(0, 7) == 0, $urandom_range(0, 1) == 1,
           rpc(), $urandom_range(0, 2) != 0, $urandom() & 32'hFFFF_FFFC, $urandom_range(0, 99) != 0);
    repeat (3) step(0, 0, 0, 0, 0, 0, 0, 1);
    chk("queue_drained", q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
